// File: rtl/modport_and.sv
// modport_and -- registered AND-reduction unit.
//
// Each non-reset clock edge samples operands a and b and registers:
//   and_vec  : bitwise a & b
//   y        : AND-reduction of a & b (1 only when every operand bit is 1)
//   ones_cnt : population count of a & b (0..WIDTH)
//   hit_cnt  : saturating count of edges that loaded y = 1
// All outputs come directly from flops; latency is one cycle.
//
// Parameters:
//   WIDTH  operand width in bits (1..16)
//   CNT_W  width of the hit counter
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset (clears all outputs)
//   a, b     WIDTH-bit operands
//   y        registered AND-reduction
//   and_vec  registered bitwise AND
//   ones_cnt registered popcount of the bitwise AND
//   hit_cnt  saturating count of y = 1 loads
module modport_and #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  output logic                           y,
  output logic [WIDTH-1:0]               and_vec,
  output logic [$clog2(WIDTH+1)-1:0]     ones_cnt,
  output logic [CNT_W-1:0]               hit_cnt
);

  localparam int unsigned ONES_W = $clog2(WIDTH + 1);

  logic              y_q,    y_d;
  logic [WIDTH-1:0]  and_q,  and_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0]  hit_q,  hit_d;

  always_comb begin
    and_d  = a & b;
    y_d    = &and_d;
    ones_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones_d = ones_d + ONES_W'(and_d[i]);
    end
    // Counter holds at all-ones instead of wrapping; an X y_d also holds it.
    hit_d = hit_q;
    if (y_d && (hit_q != '1)) begin
      hit_d = hit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q    <= 1'b0;
      and_q  <= '0;
      ones_q <= '0;
      hit_q  <= '0;
    end else begin
      y_q    <= y_d;
      and_q  <= and_d;
      ones_q <= ones_d;
      hit_q  <= hit_d;
    end
  end

  assign y        = y_q;
  assign and_vec  = and_q;
  assign ones_cnt = ones_q;
  assign hit_cnt  = hit_q;

endmodule

// File: tb/tb_modport_and.sv
// Testbench for modport_and. Two instances share stimulus: one with the
// default 16-bit hit counter and one with a 4-bit counter for saturation.
module tb_modport_and;

  logic       clk;
  logic       reset;
  logic [1:0] a;
  logic [1:0] b;

  logic        y16, y4;
  logic [1:0]  v16, v4;
  logic [1:0]  o16, o4;
  logic [15:0] h16;
  logic [3:0]  h4;

  modport_and #(.WIDTH(2), .CNT_W(16)) dut16 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .y(y16), .and_vec(v16), .ones_cnt(o16), .hit_cnt(h16)
  );

  modport_and #(.WIDTH(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .y(y4), .and_vec(v4), .ones_cnt(o4), .hit_cnt(h4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        y;
    logic [1:0]  v;
    logic [1:0]  ones;
    logic [15:0] h;
    logic [3:0]  h4;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_hit    = 0;
  int   m_hit4   = 0;

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".y"},        16'(y16), 16'(e.y));
    cmp({e.tag, ".and_vec"},  16'(v16), 16'(e.v));
    cmp({e.tag, ".ones_cnt"}, 16'(o16), 16'(e.ones));
    cmp({e.tag, ".hit_cnt"},  h16,      e.h);
    cmp({e.tag, ".y4"},       16'(y4),  16'(e.y));
    cmp({e.tag, ".hit_cnt4"}, 16'(h4),  16'(e.h4));
  endtask

  // Drive on the falling edge, predict, then check just after the rising edge.
  task automatic step(input logic [1:0] av, input logic [1:0] bv,
                      input logic rst, input string tag);
    exp_t e;
    logic [1:0] an;
    @(negedge clk);
    a = av; b = bv; reset = rst;
    e.tag = tag;
    if (rst) begin
      m_hit = 0; m_hit4 = 0;
      e.y = 1'b0; e.v = 2'b00; e.ones = 2'd0;
    end else begin
      an     = av & bv;
      e.v    = an;
      e.y    = (an == 2'b11);
      e.ones = 2'($countones(an));
      if (e.y) begin
        if (m_hit  < 65535) m_hit++;
        if (m_hit4 < 15)    m_hit4++;
      end
    end
    e.h  = 16'(m_hit);
    e.h4 = 4'(m_hit4);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    a = 2'b00; b = 2'b00; reset = 1'b1;

    // Reset held two cycles with all-ones operands
    step(2'b11, 2'b11, 1'b1, "reset0");
    step(2'b11, 2'b11, 1'b1, "reset1");

    // Exhaustive truth table
    for (int i = 0; i < 16; i++) begin
      logic [3:0] k;
      k = 4'(i);
      step(k[3:2], k[1:0], 1'b0, $sformatf("tt_a%0d_b%0d", k[3:2], k[1:0]));
    end
    cmp("tt_final_hit", h16, 16'd1);

    // Back-to-back hits from a fresh counter
    step(2'b00, 2'b00, 1'b1, "rst_b2b");
    for (int i = 0; i < 5; i++) step(2'b11, 2'b11, 1'b0, $sformatf("b2b%0d", i));

    // Partial match leaves counter unchanged
    step(2'b10, 2'b11, 1'b0, "partial");

    // Mid-run reset
    step(2'b00, 2'b00, 1'b1, "rst_mid_pre");
    for (int i = 0; i < 3; i++) step(2'b11, 2'b11, 1'b0, $sformatf("mid_hit%0d", i));
    step(2'b11, 2'b11, 1'b1, "mid_reset");
    step(2'b11, 2'b11, 1'b0, "mid_after");

    // Saturation of the 4-bit counter
    step(2'b00, 2'b00, 1'b1, "rst_sat");
    for (int i = 0; i < 20; i++) step(2'b11, 2'b11, 1'b0, $sformatf("sat%0d", i));
    step(2'b01, 2'b11, 1'b0, "sat_miss");
    cmp("sat_hold15", 16'(h4), 16'd15);
    cmp("sat_wide20", h16, 16'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
